// File: rtl/vga_frame_reader_if.sv
// -----------------------------------------------------------------------------
// vga_frame_reader_if
// Read port between the framebuffer scan-out engine and the pixel BRAM.
//
// Signals:
//   mem_en    reader -> memory  read enable (one read per cycle when high)
//   mem_addr  reader -> memory  read address, ADDR_W bits
//   mem_dout  memory -> reader  read data, PIX_W bits, {R,G,B} with R on top
//
// Handshake: there is no ready/backpressure. A read is issued on every cycle
// where mem_en is high at a rising clk edge. mem_dout carries the word for
// that address a fixed MEM_LATENCY cycles later. When mem_en is low the
// address is held and mem_dout is don't-care for that slot.
//
// Modports:
//   master  the reader (drives mem_en/mem_addr)
//   slave   the memory (drives mem_dout)
// -----------------------------------------------------------------------------
interface vga_frame_reader_if #(
   parameter int ADDR_W = 18,
   parameter int PIX_W  = 24
);
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_dout;

   modport master (
      output mem_en,
      output mem_addr,
      input  mem_dout
   );

   modport slave (
      input  mem_en,
      input  mem_addr,
      output mem_dout
   );
endinterface

// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
// Framebuffer scan-out engine in the VGA pixel clock domain. Maps visible
// coordinates to image addresses with 1x/2x/4x/8x integer upscaling, blanks
// outside the stored image, applies a colour mode and delays sync so it stays
// aligned with the pixel pipeline.
//
// Pipeline (L = MEM_LATENCY + 2 register stages, one pixel per cycle):
//   stage A   : coordinate -> col/row, class, address, read enable
//   memory    : MEM_LATENCY cycles, class/mode ride a matching delay line
//   output    : colour mode / background / blank, registered
//
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   hc_visible, vc_visible visible coordinates, 0 = outside visible area
//   hs_in, vs_in           sync from the timing driver
//   scale_sel              0=1x 1=2x 2=4x 3=8x (sampled during vertical blank)
//   mode                   00 colour 01 gray 10 invert 11 image disabled
//   bg_color               {r,g,b} fill for visible pixels outside the image
//   mem                    BRAM read port (master side)
//   vga_r, vga_g, vga_b    colour outputs
//   vga_hs, vga_vs         sync delayed by L cycles
// -----------------------------------------------------------------------------
module vga_frame_reader #(
   parameter int IMG_W       = 512,
   parameter int IMG_H       = 384,
   parameter int ADDR_W      = 18,
   parameter int PIX_W       = 24,
   parameter int OUT_BITS    = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [10:0]           hc_visible,
   input  logic [10:0]           vc_visible,
   input  logic                  hs_in,
   input  logic                  vs_in,
   input  logic [1:0]            scale_sel,
   input  logic [1:0]            mode,
   input  logic [3*OUT_BITS-1:0] bg_color,
   vga_frame_reader_if.master    mem,
   output logic [OUT_BITS-1:0]   vga_r,
   output logic [OUT_BITS-1:0]   vga_g,
   output logic [OUT_BITS-1:0]   vga_b,
   output logic                  vga_hs,
   output logic                  vga_vs
);

   localparam int L = MEM_LATENCY + 2;

   localparam logic [11:0]       IMG_W_C = 12'(IMG_W);
   localparam logic [11:0]       IMG_H_C = 12'(IMG_H);
   localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

   // BLANK must encode as zero so cleared delay-line stages emit black.
   typedef enum logic [1:0] {
      CLS_BLANK = 2'd0,
      CLS_OUT   = 2'd1,
      CLS_IN    = 2'd2
   } cls_t;

   // ---------------------------------------------------------------- shadows
   logic [1:0] scale_q;
   logic [1:0] mode_q;

   // ---------------------------------------------------------------- stage A
   logic [10:0]       col_d, row_d;
   cls_t              cls_d;
   logic [ADDR_W-1:0] addr_d;

   logic              en_q;
   logic [ADDR_W-1:0] addr_q;
   cls_t              cls_a_q;
   logic [1:0]        mode_a_q;

   always_comb begin
      // Coordinates are 1-based; subtract before scaling so column 1 maps to 0.
      col_d  = (hc_visible - 11'd1) >> scale_q;
      row_d  = (vc_visible - 11'd1) >> scale_q;
      addr_d = ADDR_W'(col_d) + IMG_W_A * ADDR_W'(row_d);
      if (hc_visible == 11'd0 || vc_visible == 11'd0) begin
         cls_d = CLS_BLANK;
      end else if ({1'b0, col_d} >= IMG_W_C || {1'b0, row_d} >= IMG_H_C ||
                   mode_q == 2'b11) begin
         cls_d = CLS_OUT;
      end else begin
         cls_d = CLS_IN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scale_q  <= 2'd1;
         mode_q   <= 2'b00;
         en_q     <= 1'b0;
         addr_q   <= '0;
         cls_a_q  <= CLS_BLANK;
         mode_a_q <= 2'b00;
      end else begin
         // Settings only change during vertical blank to avoid tearing.
         if (vc_visible == 11'd0) begin
            scale_q <= scale_sel;
            mode_q  <= mode;
         end
         en_q     <= (cls_d == CLS_IN);
         // Address holds when no read is issued, so it never leaves the image.
         if (cls_d == CLS_IN) begin
            addr_q <= addr_d;
         end
         cls_a_q  <= cls_d;
         mode_a_q <= mode_q;
      end
   end

   assign mem.mem_en   = en_q;
   assign mem.mem_addr = addr_q;

   // ------------------------------------------------- class/mode delay line
   cls_t       cls_dl_q  [MEM_LATENCY];
   logic [1:0] mode_dl_q [MEM_LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_LATENCY; i++) begin
            cls_dl_q[i]  <= CLS_BLANK;
            mode_dl_q[i] <= 2'b00;
         end
      end else begin
         cls_dl_q[0]  <= cls_a_q;
         mode_dl_q[0] <= mode_a_q;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            cls_dl_q[i]  <= cls_dl_q[i-1];
            mode_dl_q[i] <= mode_dl_q[i-1];
         end
      end
   end

   // ------------------------------------------------------- sync delay line
   logic [L-1:0] hs_dl_q, vs_dl_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_dl_q <= '0;
         vs_dl_q <= '0;
      end else begin
         hs_dl_q <= {hs_dl_q[L-2:0], hs_in};
         vs_dl_q <= {vs_dl_q[L-2:0], vs_in};
      end
   end

   assign vga_hs = hs_dl_q[L-1];
   assign vga_vs = vs_dl_q[L-1];

   // ------------------------------------------------------------ output
   logic [7:0]          pix_r, pix_g, pix_b;
   logic [9:0]          y_sum;
   logic [OUT_BITS-1:0] r_t, g_t, b_t, y_t;
   logic [OUT_BITS-1:0] r_d, g_d, b_d;
   logic [OUT_BITS-1:0] r_q, g_q, b_q;
   logic                unused_y_lsbs;

   always_comb begin
      pix_r = mem.mem_dout[23:16];
      pix_g = mem.mem_dout[15:8];
      pix_b = mem.mem_dout[7:0];
      r_t   = pix_r[7 -: OUT_BITS];
      g_t   = pix_g[7 -: OUT_BITS];
      b_t   = pix_b[7 -: OUT_BITS];
      // Y = (R + 2G + B) >> 2; top bits of the 8-bit Y are y_sum's top bits.
      y_sum = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
      y_t   = y_sum[9 -: OUT_BITS];

      r_d = '0;
      g_d = '0;
      b_d = '0;
      case (cls_dl_q[MEM_LATENCY-1])
         CLS_IN: begin
            case (mode_dl_q[MEM_LATENCY-1])
               2'b00: begin
                  r_d = r_t;
                  g_d = g_t;
                  b_d = b_t;
               end
               2'b01: begin
                  r_d = y_t;
                  g_d = y_t;
                  b_d = y_t;
               end
               2'b10: begin
                  r_d = ~r_t;
                  g_d = ~g_t;
                  b_d = ~b_t;
               end
               default: ;
            endcase
         end
         CLS_OUT: begin
            r_d = bg_color[3*OUT_BITS-1 -: OUT_BITS];
            g_d = bg_color[2*OUT_BITS-1 -: OUT_BITS];
            b_d = bg_color[OUT_BITS-1   -: OUT_BITS];
         end
         default: ;
      endcase
   end

   assign unused_y_lsbs = ^y_sum[9-OUT_BITS:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
      end else begin
         r_q <= r_d;
         g_q <= g_d;
         b_q <= b_d;
      end
   end

   assign vga_r = r_q;
   assign vga_g = g_q;
   assign vga_b = b_q;

endmodule
